branch_resolve_unit: RTL and testbench

Resolves conditional branches for the RV32 pipeline. It accepts one branch per cycle from issue, evaluates the condition through a `Comparison_Unit` instance and computes the actual next PC. It reports the outcome to commit and, on a mispredict, drives a held front-end redirect followed by a timed wrong-path flush window. It sits between the integer issue stage and the fetch redirect port.

---
 rtl/branch_pkg.sv | 39 +++
 rtl/branch_resolve_unit_comparison.sv | 23 ++
 rtl/branch_resolve_unit.sv | 155 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolve unit: funct3 values, comparator
// opcodes and the redirect/flush FSM state type.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] CMP_NONE = 2'b00;
    localparam logic [1:0] CMP_LT   = 2'b01;
    localparam logic [1:0] CMP_LTU  = 2'b10;
    localparam logic [1:0] CMP_EQ   = 2'b11;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Map a branch funct3 to the comparator operation. The inverted forms
    // (BNE/BGE/BGEU) share an opcode and are flipped by funct3[0] later.
    function automatic logic [1:0] decode_cmp(input logic [2:0] f3);
        case (f3)
            F3_BEQ, F3_BNE:   decode_cmp = CMP_EQ;
            F3_BLT, F3_BGE:   decode_cmp = CMP_LT;
            F3_BLTU, F3_BGEU: decode_cmp = CMP_LTU;
            default:          decode_cmp = CMP_NONE;
        endcase
    endfunction

    // funct3 010/011 are not branches.
    function automatic logic is_illegal(input logic [2:0] f3);
        is_illegal = (f3[2:1] == 2'b01);
    endfunction

endpackage

// File: rtl/branch_resolve_unit_comparison.sv
// Integer comparator for branch conditions: equality, signed and unsigned
// less-than. Result is in bit 0; an unknown opcode yields 0.
module Comparison_Unit
    import branch_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  cmp_op,
    output logic        result
);

    // Select the comparison requested by decode.
    always_comb begin
        result = 1'b0;
        case (cmp_op)
            CMP_EQ:  result = (a == b);
            CMP_LT:  result = ($signed(a) < $signed(b));
            CMP_LTU: result = (a < b);
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates a branch per cycle, reports the outcome,
// and on a mispredict holds a fetch redirect then discards wrong-path input
// for FLUSH_CYC cycles.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int TAG_W     = 6,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [31:0]      in_offset,
    input  logic             in_pred_taken,
    input  logic [31:0]      in_pred_target,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_taken,
    output logic             out_mispredict,
    output logic             out_illegal,
    output logic             out_misaligned,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int FC_W = $clog2(FLUSH_CYC + 1);

    state_t          state, next_state;
    logic [FC_W-1:0] flush_cnt;
    logic [1:0]      cmp_op;
    logic            cmp_res;
    logic            illegal, taken, misaligned, mispredict;
    logic [31:0]     target, fallthrough, actual_next, pred_next;
    logic            run_accept;

    Comparison_Unit u_cmp (
        .a      (in_rs1),
        .b      (in_rs2),
        .cmp_op (cmp_op),
        .result (cmp_res)
    );

    // Only inputs accepted in RUN produce a result; FLUSH swallows them.
    assign run_accept = in_valid & (state == RUN);

    // Decode, condition, next-PC arithmetic and mispredict detection.
    always_comb begin
        cmp_op      = decode_cmp(in_funct3);
        illegal     = is_illegal(in_funct3);
        taken       = ~illegal & (cmp_res ^ in_funct3[0]);
        target      = in_pc + in_offset;
        fallthrough = in_pc + 32'd4;
        actual_next = taken ? target : fallthrough;
        pred_next   = in_pred_taken ? in_pred_target : fallthrough;
        misaligned  = taken & (target[1:0] != 2'b00);
        // Misaligned targets trap at commit, so no redirect is raised here.
        mispredict  = ~illegal & ~misaligned & (actual_next != pred_next);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else        state <= next_state;
    end

    // FSM next state and handshake outputs.
    always_comb begin
        next_state     = state;
        in_ready       = 1'b1;
        redirect_valid = 1'b0;
        flush          = 1'b0;
        case (state)
            RUN: begin
                if (run_accept && mispredict) next_state = HOLD;
            end
            HOLD: begin
                in_ready       = 1'b0;
                redirect_valid = 1'b1;
                // A reset in the handshake cycle abandons the redirect.
                if (redirect_ready && rst_n) begin
                    flush      = 1'b1;
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt <= FC_W'(1)) next_state = RUN;
            end
            default: next_state = RUN;
        endcase
    end

    // Wrong-path window counter, loaded on the redirect handshake.
    always_ff @(posedge clk) begin
        if (!rst_n)
            flush_cnt <= '0;
        else if (flush)
            flush_cnt <= FC_W'(FLUSH_CYC);
        else if (state == FLUSH && flush_cnt != '0)
            flush_cnt <= flush_cnt - FC_W'(1);
    end

    // Registered result, valid the cycle after acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_tag        <= '0;
            out_taken      <= 1'b0;
            out_mispredict <= 1'b0;
            out_illegal    <= 1'b0;
            out_misaligned <= 1'b0;
        end else begin
            out_valid <= run_accept;
            if (run_accept) begin
                out_tag        <= in_tag;
                out_taken      <= taken;
                out_mispredict <= mispredict;
                out_illegal    <= illegal;
                out_misaligned <= misaligned;
            end
        end
    end

    // Redirect target captured on the mispredict; held through HOLD.
    always_ff @(posedge clk) begin
        if (!rst_n)
            redirect_pc <= '0;
        else if (run_accept && mispredict)
            redirect_pc <= actual_next;
    end

    // Saturating statistics, updated alongside the result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (run_accept) begin
            if (branch_count != '1)
                branch_count <= branch_count + CNT_W'(1);
            if (mispredict && mispredict_count != '1)
                mispredict_count <= mispredict_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus
// randomized branches against a behavioural outcome model.
module tb_branch_resolve_unit;

    localparam int TAG_W     = 6;
    localparam int FLUSH_CYC = 2;
    localparam int CNT_W     = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_funct3;
    logic [31:0]      in_pc, in_rs1, in_rs2, in_offset, in_pred_target;
    logic             in_pred_taken;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid, out_taken, out_mispredict, out_illegal, out_misaligned;
    logic [TAG_W-1:0] out_tag;
    logic             redirect_valid, redirect_ready, flush;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] branch_count, mispredict_count;

    int checks = 0;
    int errors = 0;
    int unsigned exp_bc = 0;
    int unsigned exp_mc = 0;

    branch_resolve_unit #(.TAG_W(TAG_W), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_offset(in_offset),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target), .in_tag(in_tag),
        .out_valid(out_valid), .out_tag(out_tag), .out_taken(out_taken),
        .out_mispredict(out_mispredict), .out_illegal(out_illegal),
        .out_misaligned(out_misaligned),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .flush(flush),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    // Branch semantics straight from the ISA rules.
    function automatic void model(input logic [2:0] f3, input logic [31:0] pc, rs1, rs2, off,
                                  input logic pt, input logic [31:0] ptgt,
                                  output logic tk, output logic mis, output logic ill,
                                  output logic mal, output logic [31:0] nxt);
        logic [31:0] tgt, pred;
        case (f3)
            3'd0: tk = (rs1 == rs2);
            3'd1: tk = (rs1 != rs2);
            3'd4: tk = ($signed(rs1) < $signed(rs2));
            3'd5: tk = ($signed(rs1) >= $signed(rs2));
            3'd6: tk = (rs1 < rs2);
            3'd7: tk = (rs1 >= rs2);
            default: tk = 1'b0;
        endcase
        ill  = (f3 == 3'd2) || (f3 == 3'd3);
        tgt  = pc + off;
        nxt  = tk ? tgt : pc + 32'd4;
        pred = pt ? ptgt : pc + 32'd4;
        mal  = tk && (tgt[1:0] != 2'b00);
        mis  = !ill && !mal && (nxt != pred);
    endfunction

    // Present one branch for one cycle; returns #1 after the accepting edge.
    task automatic drive_branch(input logic [2:0] f3, input logic [31:0] pc, rs1, rs2, off,
                                input logic pt, input logic [31:0] ptgt, input logic [TAG_W-1:0] tag);
        in_valid = 1'b1; in_funct3 = f3; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2;
        in_offset = off; in_pred_taken = pt; in_pred_target = ptgt; in_tag = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Complete a pending redirect immediately and sit out the flush window.
    task automatic finish_redirect();
        redirect_ready = 1'b1;
        @(posedge clk); #1;
        redirect_ready = 1'b0;
        repeat (FLUSH_CYC) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; redirect_ready = 1'b0;
        in_funct3 = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_offset = '0;
        in_pred_taken = 1'b0; in_pred_target = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (redirect_valid !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL reset_redirect: got rv=%b fl=%b want 0 0", redirect_valid, flush); end
        checks++; if (redirect_pc !== 32'd0) begin errors++; $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc); end
        checks++; if (branch_count !== 0 || mispredict_count !== 0) begin errors++; $display("FAIL reset_counters: got %0d %0d want 0 0", branch_count, mispredict_count); end
        checks++; if (out_taken !== 1'b0 || out_mispredict !== 1'b0 || out_illegal !== 1'b0 || out_misaligned !== 1'b0 || out_tag !== '0)
            begin errors++; $display("FAIL reset_out_fields: got %b%b%b%b tag %0d want 0000 tag 0", out_taken, out_mispredict, out_illegal, out_misaligned, out_tag); end
        rst_n = 1'b1;
        exp_bc = 0; exp_mc = 0;
    endtask

    task automatic test_beq_correct();
        drive_branch(3'b000, 32'h100, 32'd5, 32'd5, 32'h20, 1'b1, 32'h120, 6'd1);
        exp_bc++;
        checks++; if (out_valid !== 1'b1 || out_tag !== 6'd1) begin errors++; $display("FAIL beq_valid: got v=%b tag=%0d want 1 1", out_valid, out_tag); end
        checks++; if (out_taken !== 1'b1 || out_mispredict !== 1'b0) begin errors++; $display("FAIL beq_outcome: got tk=%b mp=%b want 1 0", out_taken, out_mispredict); end
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL beq_no_redirect: got %b want 0", redirect_valid); end
        checks++; if (branch_count !== exp_bc) begin errors++; $display("FAIL beq_count: got %0d want %0d", branch_count, exp_bc); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL beq_pulse: got %b want 0", out_valid); end
    endtask

    task automatic test_blt_hold_flush();
        drive_branch(3'b100, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 32'h0, 6'd2);
        exp_bc++; exp_mc++;
        checks++; if (out_taken !== 1'b1 || out_mispredict !== 1'b1) begin errors++; $display("FAIL blt_outcome: got tk=%b mp=%b want 1 1", out_taken, out_mispredict); end
        // Offer a branch during HOLD; it must not be taken.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h120 || in_ready !== 1'b0)
                begin errors++; $display("FAIL blt_hold%0d: got rv=%b pc=%h rdy=%b want 1 120 0", i, redirect_valid, redirect_pc, in_ready); end
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL blt_hold_accept%0d: got %b want 0", i, out_valid); end
        end
        redirect_ready = 1'b1; #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL blt_flush: got %b want 1", flush); end
        @(posedge clk); #1;
        redirect_ready = 1'b0;
        checks++; if (flush !== 1'b0 || redirect_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL blt_flush_state: got fl=%b rv=%b rdy=%b want 0 0 1", flush, redirect_valid, in_ready); end
        for (int i = 0; i < FLUSH_CYC; i++) begin
            in_funct3 = 3'b001; in_rs1 = 32'd1; in_rs2 = 32'd2;
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL blt_dropped%0d: got %b want 0", i, out_valid); end
        end
        in_valid = 1'b0;
        checks++; if (branch_count !== exp_bc || mispredict_count !== exp_mc)
            begin errors++; $display("FAIL blt_counts: got %0d %0d want %0d %0d", branch_count, mispredict_count, exp_bc, exp_mc); end
    endtask

    task automatic test_unsigned_back_to_back();
        drive_branch(3'b110, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 32'h0, 6'd3);
        exp_bc++;
        checks++; if (out_valid !== 1'b1 || out_taken !== 1'b0 || out_mispredict !== 1'b0)
            begin errors++; $display("FAIL bltu: got v=%b tk=%b mp=%b want 1 0 0", out_valid, out_taken, out_mispredict); end
        drive_branch(3'b111, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b1, 32'h120, 6'd4);
        exp_bc++;
        checks++; if (out_valid !== 1'b1 || out_taken !== 1'b1 || out_mispredict !== 1'b0 || out_tag !== 6'd4)
            begin errors++; $display("FAIL bgeu: got v=%b tk=%b mp=%b tag=%0d want 1 1 0 4", out_valid, out_taken, out_mispredict, out_tag); end
        checks++; if (branch_count !== exp_bc) begin errors++; $display("FAIL b2b_count: got %0d want %0d", branch_count, exp_bc); end
    endtask

    task automatic test_illegal_misaligned();
        drive_branch(3'b010, 32'h200, 32'd7, 32'd7, 32'h40, 1'b1, 32'h240, 6'd5);
        exp_bc++;
        checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_taken !== 1'b0 || out_mispredict !== 1'b0 || redirect_valid !== 1'b0)
            begin errors++; $display("FAIL illegal: got v=%b il=%b tk=%b mp=%b rv=%b want 1 1 0 0 0", out_valid, out_illegal, out_taken, out_mispredict, redirect_valid); end
        drive_branch(3'b001, 32'h200, 32'd1, 32'd2, 32'h22, 1'b0, 32'h0, 6'd6);
        exp_bc++;
        checks++; if (out_misaligned !== 1'b1 || out_taken !== 1'b1 || out_mispredict !== 1'b0 || out_illegal !== 1'b0 || redirect_valid !== 1'b0)
            begin errors++; $display("FAIL misaligned: got ma=%b tk=%b mp=%b il=%b rv=%b want 1 1 0 0 0", out_misaligned, out_taken, out_mispredict, out_illegal, redirect_valid); end
    endtask

    task automatic test_wrap();
        drive_branch(3'b001, 32'hFFFF_FFFC, 32'd1, 32'd2, 32'd8, 1'b0, 32'h0, 6'd7);
        exp_bc++; exp_mc++;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h4)
            begin errors++; $display("FAIL wrap_taken: got rv=%b pc=%h want 1 00000004", redirect_valid, redirect_pc); end
        finish_redirect();
        drive_branch(3'b001, 32'hFFFF_FFFC, 32'd3, 32'd3, 32'd8, 1'b1, 32'h4, 6'd8);
        exp_bc++; exp_mc++;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0 || out_taken !== 1'b0)
            begin errors++; $display("FAIL wrap_fall: got rv=%b pc=%h tk=%b want 1 00000000 0", redirect_valid, redirect_pc, out_taken); end
        finish_redirect();
        checks++; if (branch_count !== exp_bc || mispredict_count !== exp_mc)
            begin errors++; $display("FAIL wrap_counts: got %0d %0d want %0d %0d", branch_count, mispredict_count, exp_bc, exp_mc); end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] pc, rs1, rs2, off, ptgt, nxt;
        logic [TAG_W-1:0] tag;
        logic pt, tk, mis, ill, mal;
        int hold;
        for (int n = 0; n < 150; n++) begin
            f3  = 3'($urandom_range(0, 7));
            pc  = $urandom & 32'hFFFF_FFFC;
            rs1 = $urandom;
            rs2 = ($urandom_range(0, 3) == 0) ? rs1 : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 8)));
            off = ($urandom_range(0, 7) == 0) ? ($urandom & 32'h1FFE) : ($urandom & 32'h1FFC);
            if ($urandom_range(0, 1) == 1) off = -off;
            tag = TAG_W'($urandom);
            model(f3, pc, rs1, rs2, off, 1'b0, 32'h0, tk, mis, ill, mal, nxt);
            if ($urandom_range(0, 1) == 0) begin
                pt = tk; ptgt = pc + off;
            end else begin
                pt = 1'($urandom); ptgt = pc + ($urandom & 32'h3C);
            end
            model(f3, pc, rs1, rs2, off, pt, ptgt, tk, mis, ill, mal, nxt);
            drive_branch(f3, pc, rs1, rs2, off, pt, ptgt, tag);
            exp_bc++;
            if (mis) exp_mc++;
            checks++; if (out_valid !== 1'b1 || out_tag !== tag || out_taken !== tk || out_mispredict !== mis || out_illegal !== ill || out_misaligned !== mal)
                begin errors++; $display("FAIL rand%0d_result: got v=%b tag=%0d tk=%b mp=%b il=%b ma=%b want 1 %0d %b %b %b %b", n, out_valid, out_tag, out_taken, out_mispredict, out_illegal, out_misaligned, tag, tk, mis, ill, mal); end
            checks++; if (branch_count !== exp_bc || mispredict_count !== exp_mc)
                begin errors++; $display("FAIL rand%0d_counts: got %0d %0d want %0d %0d", n, branch_count, mispredict_count, exp_bc, exp_mc); end
            if (mis) begin
                hold = $urandom_range(0, 2);
                for (int h = 0; h <= hold; h++) begin
                    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== nxt || in_ready !== 1'b0)
                        begin errors++; $display("FAIL rand%0d_hold: got rv=%b pc=%h rdy=%b want 1 %h 0", n, redirect_valid, redirect_pc, in_ready, nxt); end
                    if (h < hold) begin @(posedge clk); #1; end
                end
                redirect_ready = 1'b1; #1;
                checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rand%0d_flush: got %b want 1", n, flush); end
                @(posedge clk); #1;
                redirect_ready = 1'b0;
                for (int i = 0; i < FLUSH_CYC; i++) begin
                    in_valid = 1'b1; in_rs1 = $urandom; in_rs2 = $urandom; in_pred_target = $urandom;
                    @(posedge clk); #1;
                    checks++; if (out_valid !== 1'b0 || flush !== 1'b0)
                        begin errors++; $display("FAIL rand%0d_drop%0d: got v=%b fl=%b want 0 0", n, i, out_valid, flush); end
                end
                in_valid = 1'b0;
            end else begin
                checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL rand%0d_no_redirect: got %b want 0", n, redirect_valid); end
            end
        end
    endtask

    task automatic test_reset_hold_flush();
        drive_branch(3'b100, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 32'h0, 6'd9);
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL rst_hold_setup: got %b want 1", redirect_valid); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (redirect_valid !== 1'b0 || flush !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL rst_in_hold: got rv=%b fl=%b rdy=%b v=%b want 0 0 1 0", redirect_valid, flush, in_ready, out_valid); end
        checks++; if (branch_count !== 0 || mispredict_count !== 0)
            begin errors++; $display("FAIL rst_hold_counts: got %0d %0d want 0 0", branch_count, mispredict_count); end
        rst_n = 1'b1;
        drive_branch(3'b100, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 32'h0, 6'd10);
        redirect_ready = 1'b1;
        @(posedge clk); #1;
        redirect_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (redirect_valid !== 1'b0 || flush !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL rst_in_flush: got rv=%b fl=%b rdy=%b want 0 0 1", redirect_valid, flush, in_ready); end
        checks++; if (branch_count !== 0 || mispredict_count !== 0)
            begin errors++; $display("FAIL rst_flush_counts: got %0d %0d want 0 0", branch_count, mispredict_count); end
        rst_n = 1'b1;
        exp_bc = 0; exp_mc = 0;
        // Immediately back in RUN: a correct branch is accepted and counted.
        drive_branch(3'b000, 32'h300, 32'd4, 32'd4, 32'h10, 1'b1, 32'h310, 6'd11);
        exp_bc++;
        checks++; if (out_valid !== 1'b1 || branch_count !== exp_bc)
            begin errors++; $display("FAIL rst_resume: got v=%b cnt=%0d want 1 %0d", out_valid, branch_count, exp_bc); end
    endtask

    initial begin
        test_reset();
        test_beq_correct();
        test_blt_hold_flush();
        test_unsigned_back_to_back();
        test_illegal_misaligned();
        test_wrap();
        test_random();
        test_reset_hold_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
